// File: rtl/transition_pkg.sv
// Shared types and widths for the between-level transition sequencer.
package transition_pkg;

  typedef enum logic [2:0] {
    GAME = 3'd0,
    ARM  = 3'd1,
    PRE  = 3'd2,
    RUN  = 3'd3,
    POST = 3'd4,
    WON  = 3'd5
  } state_t;

  localparam int LEVEL_W     = 2;
  localparam int FRAME_CNT_W = 10;

endpackage

// File: rtl/frame_counter.sv
// Saturating count of startOfFrame pulses with a synchronous clear.
module frame_counter
  import transition_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   i_sof,
  input  logic                   i_clear,
  output logic [FRAME_CNT_W-1:0] o_count
);

  logic [FRAME_CNT_W-1:0] r_count;

  // Clear wins over a same-clk frame so a new state never inherits that frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_sof && (r_count != {FRAME_CNT_W{1'b1}})) begin
      r_count <= r_count + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/transition_sequencer.sv
// Between-level transition FSM: restart mover, pre-roll, run to edge, post-roll, advance level.
module transition_sequencer
  import transition_pkg::*;
#(
  parameter int PRE_FRAMES     = 30,
  parameter int POST_FRAMES    = 60,
  parameter int TIMEOUT_FRAMES = 600,
  parameter int NUM_LEVELS     = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               levelDone,
  input  logic               gotToEdge,
  input  logic               skipKey,
  output logic               play,
  output logic               moverRestartN,
  output logic               transitionActive,
  output logic               levelAdvance,
  output logic [LEVEL_W-1:0] level,
  output logic               gameWon
);

  localparam logic [FRAME_CNT_W:0] PRE_LIM     = (FRAME_CNT_W+1)'(PRE_FRAMES);
  localparam logic [FRAME_CNT_W:0] POST_LIM    = (FRAME_CNT_W+1)'(POST_FRAMES);
  localparam logic [FRAME_CNT_W:0] TIMEOUT_LIM = (FRAME_CNT_W+1)'(TIMEOUT_FRAMES);
  localparam logic [LEVEL_W-1:0]   LAST_LEVEL  = LEVEL_W'(NUM_LEVELS - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_advance;
  logic                   w_clear;
  logic [FRAME_CNT_W-1:0] w_count;
  logic [FRAME_CNT_W:0]   w_count_inc;
  logic                   w_pre_done;
  logic                   w_post_done;
  logic                   w_run_timeout;
  logic                   r_play;
  logic                   r_mover_restart_n;
  logic                   r_active;
  logic                   r_level_advance;
  logic [LEVEL_W-1:0]     r_level;
  logic                   r_won;

  frame_counter u_frame_counter (
    .clk     (clk),
    .resetN  (resetN),
    .i_sof   (startOfFrame),
    .i_clear (w_clear),
    .o_count (w_count)
  );

  // "Reaches N" means this clk samples the N-th frame since the state was entered.
  assign w_count_inc   = {1'b0, w_count} + {{FRAME_CNT_W{1'b0}}, 1'b1};
  assign w_pre_done    = startOfFrame && (w_count_inc >= PRE_LIM);
  assign w_post_done   = startOfFrame && (w_count_inc >= POST_LIM);
  assign w_run_timeout = startOfFrame && (w_count_inc >= TIMEOUT_LIM);

  // Next-state decode; skipKey behaves exactly like a completed post-roll.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    case (r_state)
      GAME: begin
        if (levelDone) w_state_next = ARM;
        else           w_state_next = GAME;
      end
      ARM: w_state_next = PRE;
      PRE: begin
        if (skipKey)         w_advance    = 1'b1;
        else if (w_pre_done) w_state_next = RUN;
        else                 w_state_next = PRE;
      end
      RUN: begin
        if (skipKey)                         w_advance    = 1'b1;
        else if (gotToEdge || w_run_timeout) w_state_next = POST;
        else                                 w_state_next = RUN;
      end
      POST: begin
        if (skipKey || w_post_done) w_advance    = 1'b1;
        else                        w_state_next = POST;
      end
      WON:     w_state_next = WON;
      default: w_state_next = GAME;
    endcase
    if (w_advance) w_state_next = (r_level == LAST_LEVEL) ? WON : GAME;
    else           w_state_next = w_state_next;
  end

  assign w_clear = (w_state_next != r_state) || (r_state == GAME) || (r_state == WON);

  // State, level and outputs all decoded from the next state so they move together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state           <= GAME;
      r_play            <= 1'b0;
      r_mover_restart_n <= 1'b1;
      r_active          <= 1'b0;
      r_level_advance   <= 1'b0;
      r_level           <= {LEVEL_W{1'b0}};
      r_won             <= 1'b0;
    end else begin
      r_state           <= w_state_next;
      r_play            <= (w_state_next == RUN);
      r_mover_restart_n <= (w_state_next != ARM);
      r_active          <= (w_state_next == ARM) || (w_state_next == PRE) ||
                           (w_state_next == RUN) || (w_state_next == POST);
      r_level_advance   <= w_advance;
      r_won             <= (w_state_next == WON);
      if (w_advance && (r_level != LAST_LEVEL))
        r_level <= r_level + {{(LEVEL_W-1){1'b0}}, 1'b1};
    end
  end

  assign play             = r_play;
  assign moverRestartN    = r_mover_restart_n;
  assign transitionActive = r_active;
  assign levelAdvance     = r_level_advance;
  assign level            = r_level;
  assign gameWon          = r_won;

endmodule

// File: tb/tb_transition_sequencer.sv
// Scenario bench for transition_sequencer; expected levels queued at stimulus, popped on levelAdvance.
module tb_transition_sequencer;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       levelDone = 1'b0;
  logic       gotToEdge = 1'b0;
  logic       skipKey = 1'b0;
  logic       play;
  logic       moverRestartN;
  logic       transitionActive;
  logic       levelAdvance;
  logic [1:0] level;
  logic       gameWon;

  int n_cmp = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_lvl;

  transition_sequencer #(
    .PRE_FRAMES(30), .POST_FRAMES(60), .TIMEOUT_FRAMES(600), .NUM_LEVELS(3)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .levelDone(levelDone),
    .gotToEdge(gotToEdge), .skipKey(skipKey), .play(play), .moverRestartN(moverRestartN),
    .transitionActive(transitionActive), .levelAdvance(levelAdvance), .level(level),
    .gameWon(gameWon)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge and retire any levelAdvance against the scoreboard.
  task automatic step();
    @(negedge clk);
    if (levelAdvance && !gameWon) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_levelAdvance: got pulse at level=%0d, required none", level);
      end else begin
        exp_lvl = exp_q.pop_front();
        if (level !== exp_lvl) begin
          n_fail++;
          $display("FAIL advance_level: got %0d, required %0d", level, exp_lvl);
        end
      end
    end
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step(); step(); step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    resetN = 1'b1;
    step();
    chk("reset_play", {1'b0, play}, 2'd0);
    chk("reset_restartN", {1'b0, moverRestartN}, 2'd1);
    chk("reset_active", {1'b0, transitionActive}, 2'd0);
    chk("reset_advance", {1'b0, levelAdvance}, 2'd0);
    chk("reset_level", level, 2'd0);
    chk("reset_won", {1'b0, gameWon}, 2'd0);
  endtask

  task automatic test_nominal();
    levelDone = 1'b1; step(); levelDone = 1'b0;
    chk("nom_arm_restartN", {1'b0, moverRestartN}, 2'd0);
    chk("nom_arm_active", {1'b0, transitionActive}, 2'd1);
    step();
    chk("nom_pre_restartN", {1'b0, moverRestartN}, 2'd1);
    frames(29);
    chk("nom_pre29_play", {1'b0, play}, 2'd0);
    frame();
    chk("nom_pre30_play", {1'b0, play}, 2'd1);
    frames(49);
    chk("nom_run49_play", {1'b0, play}, 2'd1);
    gotToEdge = 1'b1; step(); gotToEdge = 1'b0;
    chk("nom_edge_play", {1'b0, play}, 2'd0);
    chk("nom_edge_active", {1'b0, transitionActive}, 2'd1);
    frames(59);
    chk("nom_post59_level", level, 2'd0);
    exp_q.push_back(2'd1);
    frame();
    chk("nom_level", level, 2'd1);
    chk("nom_done_active", {1'b0, transitionActive}, 2'd0);
    chk("nom_queue_drained", 2'(exp_q.size()), 2'd0);
  endtask

  task automatic test_reset_mid_run();
    levelDone = 1'b1; step(); levelDone = 1'b0;
    step();
    frames(40);
    chk("rst_run_play", {1'b0, play}, 2'd1);
    #2 resetN = 1'b0;
    #1;
    chk("rst_async_play", {1'b0, play}, 2'd0);
    chk("rst_async_restartN", {1'b0, moverRestartN}, 2'd1);
    chk("rst_async_active", {1'b0, transitionActive}, 2'd0);
    chk("rst_async_level", level, 2'd0);
    step();
    resetN = 1'b1;
    frames(3);
    gotToEdge = 1'b1; step(); gotToEdge = 1'b0;
    step();
    chk("rst_idle_active", {1'b0, transitionActive}, 2'd0);
    chk("rst_idle_play", {1'b0, play}, 2'd0);
  endtask

  task automatic test_skip();
    levelDone = 1'b1; step(); levelDone = 1'b0;
    step();
    frames(5);
    chk("skip_pre_play", {1'b0, play}, 2'd0);
    exp_q.push_back(2'd1);
    skipKey = 1'b1; step(); skipKey = 1'b0;
    chk("skip_adv_pulse", {1'b0, levelAdvance}, 2'd1);
    chk("skip_play", {1'b0, play}, 2'd0);
    chk("skip_active", {1'b0, transitionActive}, 2'd0);
    chk("skip_level", level, 2'd1);
  endtask

  task automatic test_timeout();
    levelDone = 1'b1; step(); levelDone = 1'b0;
    step();
    frames(30);
    frames(599);
    chk("to_run599_play", {1'b0, play}, 2'd1);
    frame();
    chk("to_run600_play", {1'b0, play}, 2'd0);
    chk("to_post_active", {1'b0, transitionActive}, 2'd1);
    frames(59);
    exp_q.push_back(2'd2);
    frame();
    chk("to_level", level, 2'd2);
    chk("to_done_active", {1'b0, transitionActive}, 2'd0);
  endtask

  task automatic test_final_level();
    levelDone = 1'b1; step(); levelDone = 1'b0;
    step();
    frames(40);
    gotToEdge = 1'b1; skipKey = 1'b1; step(); gotToEdge = 1'b0; skipKey = 1'b0;
    chk("final_won", {1'b0, gameWon}, 2'd1);
    chk("final_active", {1'b0, transitionActive}, 2'd0);
    chk("final_play", {1'b0, play}, 2'd0);
    chk("final_level", level, 2'd2);
    levelDone = 1'b1; step(); levelDone = 1'b0;
    step();
    chk("won_ld_restartN", {1'b0, moverRestartN}, 2'd1);
    chk("won_ld_active", {1'b0, transitionActive}, 2'd0);
    skipKey = 1'b1; step(); skipKey = 1'b0;
    step();
    chk("won_skip_won", {1'b0, gameWon}, 2'd1);
    chk("won_skip_level", level, 2'd2);
  endtask

  task automatic test_ignored_inputs();
    resetN = 1'b0; step(); resetN = 1'b1; step();
    skipKey = 1'b1; step(); skipKey = 1'b0;
    step();
    chk("ign_skip_active", {1'b0, transitionActive}, 2'd0);
    chk("ign_skip_level", level, 2'd0);
    levelDone = 1'b1; step(); levelDone = 1'b0;
    step();
    frames(30);
    levelDone = 1'b1; step(); levelDone = 1'b0;
    chk("ign_ld_play", {1'b0, play}, 2'd1);
    chk("ign_ld_restartN", {1'b0, moverRestartN}, 2'd1);
    gotToEdge = 1'b1; step(); gotToEdge = 1'b0;
    frames(59);
    exp_q.push_back(2'd1);
    frame();
    chk("ign_level", level, 2'd1);
    frames(5);
    chk("ign_noqueue_active", {1'b0, transitionActive}, 2'd0);
    chk("ign_noqueue_restartN", {1'b0, moverRestartN}, 2'd1);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reset_mid_run();
    test_skip();
    test_timeout();
    test_final_level();
    test_ignored_inputs();
    chk("scoreboard_empty", 2'(exp_q.size()), 2'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
